simd_lane_proc: RTL and testbench

Parametrised SIMD processing element: next generation of the array processor tile. It accepts a four-instruction setup sequence from the issuer: source A, source B, destination and op/count. It then streams element vectors from shared memory through LANES parallel ALUs and writes results back. Compared with the previous tile it adds:

- a separate destination address;
- read data that may return with variable latency;
- per-lane write masking for partial final chunks;
- a zero-count fast path.

---
 rtl/simd_lane_proc.sv | 180 ++++++++++++++++++
 tb/tb_simd_lane_proc.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_lane_proc.sv
// SIMD processing element: four-instruction setup (A, B, D, op/count), then streams
// LANES-wide chunks through per-lane ALUs with masked write-back of the final chunk.
module simd_lane_proc #(
    parameter int LANES   = 4,
    parameter int ELEM_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int COUNT_W = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic                      i_valid,
    input  logic [1:0]                i_instr_op,
    input  logic [ADDR_W-1:0]         i_instr_payload,
    output logic                      o_ack,
    output logic                      o_rd_req,
    input  logic                      i_rd_grant,
    input  logic                      i_rd_valid,
    input  logic [LANES*ELEM_W-1:0]   i_rd_data,
    output logic                      o_wr_req,
    input  logic                      i_wr_grant,
    output logic [LANES*ELEM_W-1:0]   o_wr_data,
    output logic [LANES-1:0]          o_wr_mask,
    output logic [ADDR_W-1:0]         o_addr,
    output logic                      o_busy,
    output logic                      o_finish,
    output logic [3:0]                o_dbg_state
);

    localparam int STRIDE = LANES * ELEM_W / 8;
    localparam logic [1:0] OP_LD   = 2'd1;
    localparam logic [1:0] OP_INFO = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_LD_A = 4'd1,
        S_LD_B = 4'd2,
        S_LD_D = 4'd3,
        S_INFO = 4'd4,
        S_RD_A = 4'd5,
        S_RD_B = 4'd6,
        S_WR   = 4'd7,
        S_DONE = 4'd8
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0]       addr_a, addr_b, addr_d;
    logic [LANES*ELEM_W-1:0] reg_a, reg_b, alu_res;
    logic [LANES-1:0]        lane_mask;
    logic [COUNT_W-1:0]      remaining;
    logic [1:0]              op;
    logic                    rd_granted;

    logic               ld_ok, info_ok, rd_done, last_chunk;
    logic [COUNT_W-1:0] info_count;

    assign ld_ok      = i_valid && (i_instr_op == OP_LD);
    assign info_ok    = i_valid && (i_instr_op == OP_INFO);
    assign info_count = i_instr_payload[COUNT_W+1:2];
    assign rd_done    = rd_granted && i_rd_valid;
    assign last_chunk = remaining <= COUNT_W'(LANES);

    genvar g;
    for (g = 0; g < LANES; g++) begin : g_lane
        logic [ELEM_W-1:0] a, b, prod;
        assign a    = reg_a[g*ELEM_W +: ELEM_W];
        assign b    = reg_b[g*ELEM_W +: ELEM_W];
        assign prod = a * b;
        assign alu_res[g*ELEM_W +: ELEM_W] = (op == 2'd0) ? a + b :
                                             (op == 2'd1) ? a - b :
                                             (op == 2'd2) ? prod  : a;
        assign lane_mask[g] = remaining > COUNT_W'(g);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Memory handshake: a request holds with a stable address (and write data/mask)
    // until the cycle its grant is high; read data is taken only on i_rd_valid
    // after the read has been granted.
    always_comb begin
        state_nxt = state;
        o_ack     = 1'b0;
        o_rd_req  = 1'b0;
        o_wr_req  = 1'b0;
        o_addr    = '0;
        unique case (state)
            S_IDLE: if (i_en) state_nxt = S_LD_A;
            S_LD_A: if (ld_ok) begin o_ack = 1'b1; state_nxt = S_LD_B; end
            S_LD_B: if (ld_ok) begin o_ack = 1'b1; state_nxt = S_LD_D; end
            S_LD_D: if (ld_ok) begin o_ack = 1'b1; state_nxt = S_INFO; end
            S_INFO: begin
                if (info_ok) begin
                    o_ack     = 1'b1;
                    state_nxt = (info_count == '0) ? S_DONE : S_RD_A;
                end
            end
            S_RD_A: begin
                o_addr   = addr_a;
                o_rd_req = !rd_granted;
                if (rd_done) state_nxt = S_RD_B;
            end
            S_RD_B: begin
                o_addr   = addr_b;
                o_rd_req = !rd_granted;
                if (rd_done) state_nxt = S_WR;
            end
            S_WR: begin
                o_addr   = addr_d;
                o_wr_req = 1'b1;
                if (i_wr_grant) state_nxt = last_chunk ? S_DONE : S_RD_A;
            end
            S_DONE: begin
                if (i_valid) begin
                    o_ack     = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign o_busy      = state != S_IDLE;
    assign o_finish    = state == S_DONE;
    assign o_wr_data   = (state == S_WR) ? alu_res : '0;
    assign o_wr_mask   = (state == S_WR) ? lane_mask : '0;
    assign o_dbg_state = state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_a     <= '0;
            addr_b     <= '0;
            addr_d     <= '0;
            reg_a      <= '0;
            reg_b      <= '0;
            remaining  <= '0;
            op         <= '0;
            rd_granted <= 1'b0;
        end else begin
            unique case (state)
                S_LD_A: if (ld_ok) addr_a <= i_instr_payload;
                S_LD_B: if (ld_ok) addr_b <= i_instr_payload;
                S_LD_D: if (ld_ok) addr_d <= i_instr_payload;
                S_INFO: begin
                    if (info_ok) begin
                        op        <= i_instr_payload[1:0];
                        remaining <= info_count;
                    end
                end
                S_RD_A: begin
                    if (o_rd_req && i_rd_grant) rd_granted <= 1'b1;
                    if (rd_done) begin
                        reg_a      <= i_rd_data;
                        rd_granted <= 1'b0;
                    end
                end
                S_RD_B: begin
                    if (o_rd_req && i_rd_grant) rd_granted <= 1'b1;
                    if (rd_done) begin
                        reg_b      <= i_rd_data;
                        rd_granted <= 1'b0;
                    end
                end
                S_WR: begin
                    if (i_wr_grant) begin
                        addr_a <= addr_a + ADDR_W'(STRIDE);
                        addr_b <= addr_b + ADDR_W'(STRIDE);
                        addr_d <= addr_d + ADDR_W'(STRIDE);
                        if (!last_chunk) remaining <= remaining - COUNT_W'(LANES);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_simd_lane_proc.sv
// Directed bench for simd_lane_proc: behavioural shared memory with programmable
// grant/valid latency, read-address and write scoreboards, protocol corner cases.
module tb_simd_lane_proc;

    localparam int LANES = 4;
    localparam int EW    = 32;
    localparam int AW    = 32;
    localparam int CW    = 16;
    localparam int DW    = LANES * EW;
    localparam int XW    = AW + LANES + DW;

    logic          i_clk, i_rst, i_en, i_valid;
    logic [1:0]    i_instr_op;
    logic [AW-1:0] i_instr_payload;
    logic          o_ack, o_rd_req, i_rd_grant, i_rd_valid;
    logic [DW-1:0] i_rd_data, o_wr_data;
    logic          o_wr_req, i_wr_grant;
    logic [LANES-1:0] o_wr_mask;
    logic [AW-1:0] o_addr;
    logic          o_busy, o_finish;
    logic [3:0]    o_dbg_state;

    simd_lane_proc #(.LANES(LANES), .ELEM_W(EW), .ADDR_W(AW), .COUNT_W(CW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_valid(i_valid),
        .i_instr_op(i_instr_op), .i_instr_payload(i_instr_payload), .o_ack(o_ack),
        .o_rd_req(o_rd_req), .i_rd_grant(i_rd_grant), .i_rd_valid(i_rd_valid),
        .i_rd_data(i_rd_data), .o_wr_req(o_wr_req), .i_wr_grant(i_wr_grant),
        .o_wr_data(o_wr_data), .o_wr_mask(o_wr_mask), .o_addr(o_addr),
        .o_busy(o_busy), .o_finish(o_finish), .o_dbg_state(o_dbg_state)
    );

    // Clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack4(input logic [EW-1:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    // Scoreboard queues: expected writes {addr, mask, data} and read addresses
    logic [XW-1:0] exp_q[$];
    logic [AW-1:0] rd_exp_q[$];
    logic [DW-1:0] mem [logic [AW-1:0]];

    // Memory responder configuration and state
    int rd_gnt_dly = 0, wr_gnt_dly = 0, val_dly = 1;
    bit spurious = 1'b0;
    int rd_wait = 0, wr_wait = 0, v_wait = 0, rd_cnt = 0, wr_cnt = 0;
    bit rd_out = 1'b0, rd_stable = 1'b1, wr_stable = 1'b1;
    logic [AW-1:0] req_addr, rd_addr, w_addr, exp_addr;
    logic [DW-1:0] w_data;
    logic [LANES-1:0] w_mask;
    logic [XW-1:0] exp_w;

    initial begin
        i_rd_grant = 1'b0; i_rd_valid = 1'b0; i_rd_data = '0; i_wr_grant = 1'b0;
        forever begin
            @(posedge i_clk); #1;
            i_rd_grant = 1'b0; i_rd_valid = 1'b0; i_wr_grant = 1'b0;
            if (i_rst) begin
                rd_wait = 0; wr_wait = 0; rd_out = 1'b0;
            end else if (rd_out) begin
                v_wait++;
                if (v_wait >= val_dly) begin
                    i_rd_valid = 1'b1;
                    i_rd_data  = mem[rd_addr];
                    rd_out     = 1'b0;
                end
            end else if (o_rd_req) begin
                if (rd_wait == 0) begin req_addr = o_addr; rd_stable = 1'b1; end
                else if (o_addr !== req_addr) rd_stable = 1'b0;
                if (rd_wait >= rd_gnt_dly) begin
                    i_rd_grant = 1'b1; rd_out = 1'b1; v_wait = 0; rd_addr = req_addr;
                    rd_wait = 0; rd_cnt++;
                    check("rd_addr_stable", rd_stable, 1'b1);
                    exp_addr = (rd_exp_q.size() > 0) ? rd_exp_q.pop_front() : 'x;
                    check("rd_addr", req_addr, exp_addr);
                end else begin
                    rd_wait++;
                    if (spurious) begin i_rd_valid = 1'b1; i_rd_data = {4{32'hDEADBEEF}}; end
                end
            end else if (o_wr_req) begin
                if (wr_wait == 0) begin
                    w_addr = o_addr; w_data = o_wr_data; w_mask = o_wr_mask; wr_stable = 1'b1;
                end else if (o_addr !== w_addr || o_wr_data !== w_data || o_wr_mask !== w_mask) begin
                    wr_stable = 1'b0;
                end
                if (wr_wait >= wr_gnt_dly) begin
                    i_wr_grant = 1'b1; wr_wait = 0; wr_cnt++;
                    check("wr_stable", wr_stable, 1'b1);
                    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                    check("wr_txn", {w_addr, w_mask, w_data}, exp_w);
                end else begin
                    wr_wait++;
                end
            end
        end
    end

    // Driver tasks: all called at a falling edge, return at a falling edge
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] pl, input logic exp_ack,
                         input string tag);
        i_valid = 1'b1; i_instr_op = op; i_instr_payload = pl;
        #1 check(tag, o_ack, exp_ack);
        @(negedge i_clk);
        i_valid = 1'b0; i_instr_op = 2'd0;
    endtask

    task automatic start_op(input logic [AW-1:0] a, b, d, input logic [1:0] op,
                            input logic [CW-1:0] cnt);
        i_en = 1'b1;
        @(negedge i_clk);
        i_en = 1'b0;
        issue(2'd1, a, 1'b1, "ld_a_ack");
        issue(2'd1, b, 1'b1, "ld_b_ack");
        issue(2'd1, d, 1'b1, "ld_d_ack");
        issue(2'd2, AW'({cnt, op}), 1'b1, "info_ack");
    endtask

    task automatic wait_finish(output int n);
        n = 0;
        while (n < 500) begin
            n++;
            if (o_finish) break;
            @(negedge i_clk);
        end
        check("finish_seen", o_finish, 1'b1);
    endtask

    task automatic finish_ack();
        i_valid = 1'b1; i_instr_op = 2'd3;
        #1 check("done_ack", o_ack, 1'b1);
        @(negedge i_clk);
        i_valid = 1'b0; i_instr_op = 2'd0;
        check("idle_after_done", o_dbg_state, 4'd0);
        check("busy_after_done", o_busy, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, o_dbg_state, 4'd0);
        check({tag, "_outs"}, {o_ack, o_rd_req, o_wr_req, o_busy, o_finish, o_wr_mask}, 9'd0);
        check({tag, "_addr"}, o_addr, 32'd0);
        check({tag, "_wdata"}, o_wr_data, 128'd0);
    endtask

    int lat, rc, wc, n;

    initial begin
        i_rst = 1'b1; i_en = 1'b0; i_valid = 1'b0; i_instr_op = 2'd0; i_instr_payload = '0;
        repeat (3) @(negedge i_clk);
        check_all_zero("reset");
        i_rst = 1'b0;
        @(negedge i_clk);

        // Basic ADD, minimum latency
        mem[32'h100] = pack4(1, 2, 3, 4);
        mem[32'h200] = pack4(10, 20, 30, 40);
        rd_exp_q.push_back(32'h100); rd_exp_q.push_back(32'h200);
        exp_q.push_back({32'h300, 4'b1111, pack4(11, 22, 33, 44)});
        start_op(32'h100, 32'h200, 32'h300, 2'd0, 16'd4);
        wait_finish(lat);
        check("add_latency", lat, 6);
        finish_ack();

        // Partial final chunk with SUB (lane 3 of chunk 1 wraps below zero)
        mem[32'h1000] = pack4(100, 200, 300, 400);
        mem[32'h1010] = pack4(50, 60, 70, 3);
        mem[32'h2000] = pack4(1, 2, 3, 4);
        mem[32'h2010] = pack4(5, 6, 7, 8);
        rd_exp_q.push_back(32'h1000); rd_exp_q.push_back(32'h2000);
        rd_exp_q.push_back(32'h1010); rd_exp_q.push_back(32'h2010);
        exp_q.push_back({32'h3000, 4'b1111, pack4(99, 198, 297, 396)});
        exp_q.push_back({32'h3010, 4'b0011, pack4(45, 54, 63, 32'hFFFFFFFB)});
        start_op(32'h1000, 32'h2000, 32'h3000, 2'd1, 16'd6);
        wait_finish(lat);
        finish_ack();

        // Zero count fast path
        rc = rd_cnt; wc = wr_cnt;
        start_op(32'h1000, 32'h2000, 32'h3000, 2'd0, 16'd0);
        wait_finish(lat);
        check("zero_latency", lat, 1);
        check("zero_reads", rd_cnt, rc);
        check("zero_writes", wr_cnt, wc);
        finish_ack();

        // Backpressure and late read data with MUL; stray valids before grant
        rd_gnt_dly = 3; wr_gnt_dly = 3; val_dly = 4; spurious = 1'b1;
        mem[32'h400] = pack4(32'hFFFFFFFF, 3, 32'h10000, 7);
        mem[32'h500] = pack4(2, 5, 32'h10000, 0);
        rd_exp_q.push_back(32'h400); rd_exp_q.push_back(32'h500);
        exp_q.push_back({32'h600, 4'b1111, pack4(32'hFFFFFFFE, 15, 0, 0)});
        start_op(32'h400, 32'h500, 32'h600, 2'd2, 16'd4);
        wait_finish(lat);
        finish_ack();
        rd_gnt_dly = 0; wr_gnt_dly = 0; val_dly = 1; spurious = 1'b0;

        // In-place COPY, two elements
        mem[32'h700] = pack4(9, 8, 7, 6);
        mem[32'h800] = pack4(1, 1, 1, 1);
        rd_exp_q.push_back(32'h700); rd_exp_q.push_back(32'h800);
        exp_q.push_back({32'h700, 4'b0011, pack4(9, 8, 7, 6)});
        start_op(32'h700, 32'h800, 32'h700, 2'd3, 16'd2);
        wait_finish(lat);
        finish_ack();

        // Protocol robustness: wrong opcode, valid low, reset during WR
        i_en = 1'b1;
        @(negedge i_clk);
        i_en = 1'b0;
        issue(2'd2, AW'(32'h10), 1'b0, "info_in_lda_ack");
        check("info_in_lda_state", o_dbg_state, 4'd1);
        i_instr_op = 2'd1; i_instr_payload = 32'h100;
        #1 check("valid_low_ack", o_ack, 1'b0);
        @(negedge i_clk);
        check("valid_low_state", o_dbg_state, 4'd1);
        wr_gnt_dly = 1000;
        rd_exp_q.push_back(32'h100); rd_exp_q.push_back(32'h200);
        issue(2'd1, 32'h100, 1'b1, "rb_ld_a_ack");
        issue(2'd1, 32'h200, 1'b1, "rb_ld_b_ack");
        issue(2'd1, 32'h300, 1'b1, "rb_ld_d_ack");
        issue(2'd2, AW'({16'd4, 2'd0}), 1'b1, "rb_info_ack");
        n = 0;
        while (!o_wr_req && n < 50) begin @(negedge i_clk); n++; end
        check("rb_wr_req_seen", o_wr_req, 1'b1);
        check("rb_wr_data", o_wr_data, pack4(11, 22, 33, 44));
        i_rst = 1'b1;
        @(negedge i_clk);
        check_all_zero("rst_in_wr");
        i_rst = 1'b0;
        wr_gnt_dly = 0;
        repeat (3) @(negedge i_clk);
        check("idle_hold", o_dbg_state, 4'd0);

        check("wr_queue_drained", exp_q.size(), 0);
        check("rd_queue_drained", rd_exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
